// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared constants and FSM state encodings for the AXI4-Lite memory slave.
package axi_lite_mem_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_MEM  = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_MEM  = 2'd1,
        R_RESP = 2'd2
    } rstate_e;

endpackage

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave bridging to a simple single-port-style memory with
// independent write and read FSMs that may run concurrently.
module axi_lite_mem_slave
    import axi_lite_mem_slave_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESETn,

    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,

    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,

    output logic              MEM_CS,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_WADDR,
    output logic [ADDR_W-1:0] MEM_RADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam logic [ADDR_W:0] MAX_ADDR = (ADDR_W+1)'((2 ** ADDR_W) - (DATA_W / 8));

    function automatic logic inRange(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} <= MAX_ADDR;
    endfunction

    logic              readyEn_q;

    wstate_e           wState_q, wState_d;
    logic              awHeld_q, awHeld_d;
    logic              wHeld_q, wHeld_d;
    logic [ADDR_W-1:0] awAddr_q, awAddr_d;
    logic [DATA_W-1:0] wData_q, wData_d;
    logic [1:0]        bResp_q, bResp_d;
    logic [ADDR_W-1:0] memWaddr_q, memWaddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;

    rstate_e           rState_q, rState_d;
    logic [1:0]        rResp_q, rResp_d;
    logic [DATA_W-1:0] rData_q, rData_d;
    logic [ADDR_W-1:0] memRaddr_q, memRaddr_d;

    logic              awReady, wReady, bValid, wMemPhase;
    logic              awFire, wFire;
    logic [ADDR_W-1:0] curAwAddr;
    logic [DATA_W-1:0] curWData;
    logic              arReady, rValid, rMemPhase;

    // Keeps the ready outputs low until the first rising edge after reset release.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            readyEn_q <= 1'b0;
        end else begin
            readyEn_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wState_q   <= W_IDLE;
            awHeld_q   <= 1'b0;
            wHeld_q    <= 1'b0;
            awAddr_q   <= '0;
            wData_q    <= '0;
            bResp_q    <= RESP_OKAY;
            memWaddr_q <= '0;
            memWdata_q <= '0;
        end else begin
            wState_q   <= wState_d;
            awHeld_q   <= awHeld_d;
            wHeld_q    <= wHeld_d;
            awAddr_q   <= awAddr_d;
            wData_q    <= wData_d;
            bResp_q    <= bResp_d;
            memWaddr_q <= memWaddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    always_comb begin
        wState_d   = wState_q;
        awHeld_d   = awHeld_q;
        wHeld_d    = wHeld_q;
        awAddr_d   = awAddr_q;
        wData_d    = wData_q;
        bResp_d    = bResp_q;
        memWaddr_d = memWaddr_q;
        memWdata_d = memWdata_q;
        awReady    = 1'b0;
        wReady     = 1'b0;
        bValid     = 1'b0;
        wMemPhase  = 1'b0;
        awFire     = 1'b0;
        wFire      = 1'b0;
        curAwAddr  = awHeld_q ? awAddr_q : AWADDR;
        curWData   = wHeld_q ? wData_q : WDATA;

        case (wState_q)
            W_IDLE: begin
                awReady = readyEn_q && !awHeld_q;
                wReady  = readyEn_q && !wHeld_q;
                awFire  = AWVALID && awReady;
                wFire   = WVALID && wReady;
                if (awFire) begin
                    awHeld_d = 1'b1;
                    awAddr_d = AWADDR;
                end
                if (wFire) begin
                    wHeld_d = 1'b1;
                    wData_d = WDATA;
                end
                // Both beats complete (either held or arriving now): launch the write.
                if ((awHeld_q || awFire) && (wHeld_q || wFire)) begin
                    awHeld_d = 1'b0;
                    wHeld_d  = 1'b0;
                    if (inRange(curAwAddr)) begin
                        wState_d   = W_MEM;
                        bResp_d    = RESP_OKAY;
                        memWaddr_d = curAwAddr;
                        memWdata_d = curWData;
                    end else begin
                        wState_d = W_RESP;
                        bResp_d  = RESP_SLVERR;
                    end
                end
            end
            W_MEM: begin
                wMemPhase = 1'b1;
                wState_d  = W_RESP;
            end
            W_RESP: begin
                bValid = 1'b1;
                if (BREADY) begin
                    wState_d = W_IDLE;
                end
            end
            default: wState_d = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rState_q   <= R_IDLE;
            rResp_q    <= RESP_OKAY;
            rData_q    <= '0;
            memRaddr_q <= '0;
        end else begin
            rState_q   <= rState_d;
            rResp_q    <= rResp_d;
            rData_q    <= rData_d;
            memRaddr_q <= memRaddr_d;
        end
    end

    always_comb begin
        rState_d   = rState_q;
        rResp_d    = rResp_q;
        rData_d    = rData_q;
        memRaddr_d = memRaddr_q;
        arReady    = 1'b0;
        rValid     = 1'b0;
        rMemPhase  = 1'b0;

        case (rState_q)
            R_IDLE: begin
                arReady = readyEn_q;
                if (ARVALID && arReady) begin
                    if (inRange(ARADDR)) begin
                        rState_d   = R_MEM;
                        rResp_d    = RESP_OKAY;
                        memRaddr_d = ARADDR;
                    end else begin
                        rState_d = R_RESP;
                        rResp_d  = RESP_SLVERR;
                        rData_d  = '0;
                    end
                end
            end
            R_MEM: begin
                // Memory drives MEM_RDATA on the falling edge, so it is settled here.
                rMemPhase = 1'b1;
                rData_d   = MEM_RDATA;
                rState_d  = R_RESP;
            end
            R_RESP: begin
                rValid = 1'b1;
                if (RREADY) begin
                    rState_d = R_IDLE;
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    assign AWREADY   = awReady;
    assign WREADY    = wReady;
    assign BVALID    = bValid;
    assign BRESP     = bResp_q;
    assign ARREADY   = arReady;
    assign RVALID    = rValid;
    assign RRESP     = rResp_q;
    assign RDATA     = rData_q;
    assign MEM_CS    = wMemPhase || rMemPhase;
    assign MEM_WE    = wMemPhase;
    assign MEM_WADDR = memWaddr_q;
    assign MEM_RADDR = memRaddr_q;
    assign MEM_WDATA = memWdata_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave: directed scenarios plus
// randomized traffic checked against a byte-array reference memory.
module tb_axi_lite_mem_slave;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int MAXA = 124;

    logic              CLK = 1'b0;
    logic              RESETn = 1'b0;
    logic [ADDR_W-1:0] AWADDR = '0;
    logic              AWVALID = 1'b0;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA = '0;
    logic              WVALID = 1'b0;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic [ADDR_W-1:0] ARADDR = '0;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic              MEM_CS, MEM_WE;
    logic [ADDR_W-1:0] MEM_WADDR, MEM_RADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int weCount = 0;
    int csCount = 0;
    int weCyc = -1;
    logic [ADDR_W-1:0] weAddr = '0;
    logic [DATA_W-1:0] weData = '0;

    logic [7:0] sram   [0:127];
    logic [7:0] refMem [0:127];

    axi_lite_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .MEM_CS(MEM_CS), .MEM_WE(MEM_WE),
        .MEM_WADDR(MEM_WADDR), .MEM_RADDR(MEM_RADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Attached memory: writes on the rising edge, read port updated on the falling edge.
    always @(posedge CLK) begin
        if (MEM_CS && MEM_WE) begin
            for (int i = 0; i < 4; i++) begin
                sram[7'(int'(MEM_WADDR) + i)] <= MEM_WDATA[8*i +: 8];
            end
        end
    end

    always @(negedge CLK) begin
        MEM_RDATA <= {sram[7'(int'(MEM_RADDR) + 3)], sram[7'(int'(MEM_RADDR) + 2)],
                      sram[7'(int'(MEM_RADDR) + 1)], sram[MEM_RADDR]};
    end

    always @(negedge CLK) begin
        if (MEM_CS) csCount <= csCount + 1;
        if (MEM_CS && MEM_WE) begin
            weCount <= weCount + 1;
            weCyc   <= cyc;
            weAddr  <= MEM_WADDR;
            weData  <= MEM_WDATA;
        end
    end

    function automatic logic [31:0] refRead(input int a);
        logic [31:0] r;
        r = '0;
        if (a <= MAXA) begin
            for (int i = 0; i < 4; i++) r[8*i +: 8] = refMem[a + i];
        end
        return r;
    endfunction

    function automatic void refWrite(input int a, input logic [31:0] d);
        if (a <= MAXA) begin
            for (int i = 0; i < 4; i++) refMem[a + i] = d[8*i +: 8];
        end
    endfunction

    task automatic axiWrite(input logic [6:0] addr, input logic [31:0] data,
                            input int wLead, input int awLead,
                            output logic [1:0] resp, output int bCyc, output bit timedOut);
        bit awDone, wDone, got;
        int k;
        awDone = 0; wDone = 0; got = 0; k = 0;
        timedOut = 0; resp = 2'bxx; bCyc = -1;
        while (!(awDone && wDone) && k < 20) begin
            @(negedge CLK);
            AWADDR  = addr;
            WDATA   = data;
            AWVALID = !awDone && (k >= awLead);
            WVALID  = !wDone && (k >= wLead);
            #1;
            if (AWVALID && AWREADY) awDone = 1;
            if (WVALID && WREADY) wDone = 1;
            k++;
        end
        @(negedge CLK);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        if (!(awDone && wDone)) begin
            timedOut = 1;
            return;
        end
        BREADY = 1'b1;
        for (int j = 0; j < 20; j++) begin
            #1;
            if (BVALID) begin
                resp = BRESP;
                bCyc = cyc;
                got = 1;
                break;
            end
            @(negedge CLK);
        end
        if (got) begin
            @(posedge CLK);
            @(negedge CLK);
        end else begin
            timedOut = 1;
        end
        BREADY = 1'b0;
    endtask

    task automatic axiRead(input logic [6:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int hsCyc, output int rvCyc,
                           output bit stable, output bit timedOut);
        bit done, got;
        int k;
        done = 0; got = 0; k = 0;
        timedOut = 0; stable = 1; data = 'x; resp = 2'bxx; hsCyc = -1; rvCyc = -1;
        while (!done && k < 20) begin
            @(negedge CLK);
            ARADDR  = addr;
            ARVALID = 1'b1;
            #1;
            if (ARREADY) done = 1;
            k++;
        end
        if (!done) begin
            ARVALID = 1'b0;
            timedOut = 1;
            return;
        end
        @(posedge CLK);
        #1;
        hsCyc = cyc;
        @(negedge CLK);
        ARVALID = 1'b0;
        for (int j = 0; j < 20; j++) begin
            #1;
            if (RVALID) begin
                rvCyc = cyc;
                data = RDATA;
                resp = RRESP;
                got = 1;
                break;
            end
            @(negedge CLK);
        end
        if (!got) begin
            timedOut = 1;
            return;
        end
        repeat (hold) begin
            @(negedge CLK);
            #1;
            if (RVALID !== 1'b1 || RDATA !== data || RRESP !== resp) stable = 0;
        end
        RREADY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA,
             MEM_CS, MEM_WE, MEM_WADDR, MEM_RADDR, MEM_WDATA} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b rdata=%h cs=%b we=%b, expected all zero",
                     AWREADY, WREADY, ARREADY, BVALID, RVALID, RDATA, MEM_CS, MEM_WE);
        end
        RESETn = 1'b1;
        #1;
        total++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL ready_before_edge: got %b expected 000", {AWREADY, WREADY, ARREADY});
        end
        @(posedge CLK);
        #1;
        total++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            bad++;
            $display("[TB] FAIL ready_after_edge: got %b expected 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_read_basic();
        logic [31:0] d; logic [1:0] r; int hs, rv, cs0; bit st, to;
        cs0 = csCount;
        axiRead(7'd0, 0, d, r, hs, rv, st, to);
        total++;
        if (to !== 1'b0) begin bad++; $display("[TB] FAIL read0_timeout: got timeout expected response"); end
        total++;
        if (rv !== hs + 1) begin bad++; $display("[TB] FAIL read0_latency: got rvalid cycle %0d expected %0d", rv, hs + 1); end
        total++;
        if (d !== 32'h03020100) begin bad++; $display("[TB] FAIL read0_data: got %h expected 03020100", d); end
        total++;
        if (r !== OKAY) begin bad++; $display("[TB] FAIL read0_resp: got %b expected %b", r, OKAY); end
        total++;
        if (csCount - cs0 !== 1) begin bad++; $display("[TB] FAIL read0_cs_pulses: got %0d expected 1", csCount - cs0); end
    endtask

    task automatic test_read_stall();
        logic [31:0] d; logic [1:0] r; int hs, rv; bit st, to;
        axiRead(7'd1, 3, d, r, hs, rv, st, to);
        total++;
        if (to !== 1'b0 || d !== 32'h04030201) begin
            bad++; $display("[TB] FAIL read1_data: got %h (timeout=%b) expected 04030201", d, to);
        end
        total++;
        if (st !== 1'b1) begin bad++; $display("[TB] FAIL read1_stable: got unstable response expected stable"); end
        #1;
        total++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            bad++; $display("[TB] FAIL read1_idle: got arready=%b rvalid=%b expected 1 0", ARREADY, RVALID);
        end
    endtask

    task automatic test_write_w_first();
        logic [1:0] r; int bc, we0; bit to;
        logic [31:0] d; logic [1:0] rr; int hs, rv; bit st, to2;
        we0 = weCount;
        axiWrite(7'd8, 32'hDEADBEEF, 0, 2, r, bc, to);
        refWrite(8, 32'hDEADBEEF);
        total++;
        if (to !== 1'b0 || r !== OKAY) begin bad++; $display("[TB] FAIL wfirst_resp: got %b (timeout=%b) expected %b", r, to, OKAY); end
        total++;
        if (weCount - we0 !== 1) begin bad++; $display("[TB] FAIL wfirst_we_pulses: got %0d expected 1", weCount - we0); end
        total++;
        if (weAddr !== 7'd8 || weData !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL wfirst_mem_bus: got addr=%0d data=%h expected 8 deadbeef", weAddr, weData);
        end
        total++;
        if (bc !== weCyc + 1) begin bad++; $display("[TB] FAIL wfirst_bvalid_timing: got cycle %0d expected %0d", bc, weCyc + 1); end
        axiRead(7'd8, 0, d, rr, hs, rv, st, to2);
        total++;
        if (d !== refRead(8)) begin bad++; $display("[TB] FAIL wfirst_readback: got %h expected %h", d, refRead(8)); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] r; int hs, rv, cs0, we0, bc; bit st, to;
        cs0 = csCount;
        axiRead(7'd125, 0, d, r, hs, rv, st, to);
        total++;
        if (to !== 1'b0 || r !== SLVERR) begin bad++; $display("[TB] FAIL oor_read_resp: got %b (timeout=%b) expected %b", r, to, SLVERR); end
        total++;
        if (d !== 32'h0) begin bad++; $display("[TB] FAIL oor_read_data: got %h expected 0", d); end
        total++;
        if (csCount !== cs0) begin bad++; $display("[TB] FAIL oor_read_cs: got %0d pulses expected 0", csCount - cs0); end
        cs0 = csCount;
        we0 = weCount;
        axiWrite(7'd126, 32'h12345678, 0, 0, r, bc, to);
        total++;
        if (to !== 1'b0 || r !== SLVERR) begin bad++; $display("[TB] FAIL oor_write_resp: got %b (timeout=%b) expected %b", r, to, SLVERR); end
        total++;
        if (weCount !== we0 || csCount !== cs0) begin
            bad++; $display("[TB] FAIL oor_write_we: got we=%0d cs=%0d pulses expected 0 0", weCount - we0, csCount - cs0);
        end
    endtask

    task automatic test_concurrent();
        logic [31:0] d; logic [1:0] rr, wr; int hs, rv, bc; bit st, rto, wto;
        refWrite(16, 32'hA5A55A5A);
        fork
            axiWrite(7'd16, 32'hA5A55A5A, 0, 0, wr, bc, wto);
            axiRead(7'd4, 0, d, rr, hs, rv, st, rto);
        join
        total++;
        if (wto !== 1'b0 || rto !== 1'b0 || wr !== OKAY || rr !== OKAY) begin
            bad++; $display("[TB] FAIL conc_resp: got w=%b r=%b (to=%b%b) expected 00 00", wr, rr, wto, rto);
        end
        total++;
        if (d !== refRead(4)) begin bad++; $display("[TB] FAIL conc_read_data: got %h expected %h", d, refRead(4)); end
        total++;
        if (weCyc !== hs) begin bad++; $display("[TB] FAIL conc_overlap: got write phase cycle %0d expected %0d", weCyc, hs); end
        axiRead(7'd16, 0, d, rr, hs, rv, st, rto);
        total++;
        if (d !== refRead(16)) begin bad++; $display("[TB] FAIL conc_readback: got %h expected %h", d, refRead(16)); end
    endtask

    task automatic test_reset_mid_read();
        bit seen, stale;
        seen = 0; stale = 0;
        @(negedge CLK);
        ARADDR = 7'd0; ARVALID = 1'b1; RREADY = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        ARVALID = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            if (RVALID) begin seen = 1; break; end
            @(negedge CLK);
        end
        total++;
        if (seen !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_rvalid: got no rvalid expected rvalid before reset"); end
        #2;
        RESETn = 1'b0;
        #1;
        total++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b0 || RDATA !== '0) begin
            bad++; $display("[TB] FAIL rstmid_async: got rvalid=%b arready=%b rdata=%h expected 0 0 0", RVALID, ARREADY, RDATA);
        end
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        #1;
        total++;
        if (ARREADY !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_arready_early: got %b expected 0", ARREADY); end
        @(posedge CLK);
        #1;
        total++;
        if (ARREADY !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_arready: got %b expected 1", ARREADY); end
        RREADY = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            if (RVALID) stale = 1;
        end
        RREADY = 1'b0;
        total++;
        if (stale !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_stale: got stale rvalid expected none"); end
    endtask

    task automatic test_random();
        logic [31:0] d, exp; logic [1:0] r, er; int hs, rv, bc, we0, a; bit st, to;
        for (int n = 0; n < 40; n++) begin
            a = int'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                we0 = weCount;
                axiWrite(7'(a), d, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), r, bc, to);
                refWrite(a, d);
                er = (a <= MAXA) ? OKAY : SLVERR;
                total++;
                if (to !== 1'b0 || r !== er) begin
                    bad++; $display("[TB] FAIL rand_write_resp: addr %0d got %b (timeout=%b) expected %b", a, r, to, er);
                end
                total++;
                if (weCount - we0 !== ((a <= MAXA) ? 1 : 0)) begin
                    bad++; $display("[TB] FAIL rand_write_we: addr %0d got %0d pulses expected %0d", a, weCount - we0, (a <= MAXA) ? 1 : 0);
                end
            end else begin
                axiRead(7'(a), int'($urandom_range(0, 2)), d, r, hs, rv, st, to);
                exp = refRead(a);
                er = (a <= MAXA) ? OKAY : SLVERR;
                total++;
                if (to !== 1'b0 || r !== er || d !== exp || st !== 1'b1) begin
                    bad++; $display("[TB] FAIL rand_read: addr %0d got %h/%b stable=%b expected %h/%b", a, d, r, st, exp, er);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            sram[i]   = 8'(i);
            refMem[i] = 8'(i);
        end
        test_reset();
        test_read_basic();
        test_read_stall();
        test_write_w_first();
        test_out_of_range();
        test_concurrent();
        test_reset_mid_read();
        test_random();
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_lite_mem_slave.md
AXI_LITE_MEM_SLAVE -- requirements
Module: axi_lite_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, byte-address width of the attached memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits; DATA_W/8 bytes per access.
REQ-003 SHALL use one clock and an asynchronous active-low reset:
- CLK  in  1  sole clock; all state updates on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
REQ-004 SHALL provide these AXI4-Lite slave ports:
- AWADDR  in  ADDR_W  write address
- AWVALID in 1; AWREADY out 1
- WDATA  in  DATA_W  write data
- WVALID in 1; WREADY out 1
- BRESP  out  2  write response
- BVALID out 1; BREADY in 1
- ARADDR  in  ADDR_W  read address
- ARVALID in 1; ARREADY out 1
- RDATA  out  DATA_W  read data
- RRESP  out  2  read response
- RVALID out 1; RREADY in 1
REQ-005 SHALL provide these memory-side ports:
- MEM_CS  out  1  chip select
- MEM_WE  out  1  write enable
- MEM_WADDR  out  ADDR_W  write address
- MEM_RADDR  out  ADDR_W  read address
- MEM_WDATA  out  DATA_W  write data
- MEM_RDATA  in  DATA_W  read data; the memory updates it on the falling edge of CLK.

Function
REQ-006 SHALL implement independent write and read FSMs; both may be busy concurrently.
REQ-007 The write FSM SHALL have states W_IDLE, W_MEM and W_RESP.
- W_IDLE: AWREADY=1 until the AW beat is accepted; WREADY=1 until the W beat is accepted.
- AW and W beats may arrive in either order or in the same cycle; each is latched on its own.
- W_IDLE -> W_MEM on the edge at which both beats are held.
REQ-008 In W_MEM, for exactly one cycle: MEM_CS=1, MEM_WE=1, MEM_WADDR=latched address, MEM_WDATA=latched data. Then W_MEM -> W_RESP.
REQ-009 In W_RESP, BVALID=1 and BRESP SHALL stay stable until BREADY. W_RESP -> W_IDLE on the edge with BVALID&&BREADY.
REQ-010 The read FSM SHALL have states R_IDLE, R_MEM and R_RESP.
- R_IDLE: ARREADY=1.
- On ARVALID&&ARREADY -> R_MEM.
REQ-011 In R_MEM, for one cycle: MEM_CS=1, MEM_RADDR=latched address. At the closing edge, RDATA<=MEM_RDATA and the FSM moves to R_RESP. RVALID therefore rises exactly one cycle after the AR handshake.
REQ-012 In R_RESP, RVALID=1 with RDATA and RRESP held until RREADY. R_RESP -> R_IDLE on the edge with RVALID&&RREADY.
REQ-013 MEM_CS SHALL be the OR of both FSMs' memory phases. MEM_WE SHALL be 1 only in W_MEM.
REQ-014 Out-of-range address: an address greater than 2^ADDR_W - DATA_W/8 (124 at defaults) SHALL produce SLVERR (2'b10). The memory phase is skipped: no MEM_CS/MEM_WE pulse, RDATA=0, FSM goes straight to the response state.
REQ-015 In-range addresses, aligned or unaligned, SHALL return OKAY (2'b00). Unaligned reads return bytes addr..addr+3, little-endian.
REQ-016 Simultaneous read and write to overlapping bytes SHALL need no ordering logic. Read data reflects memory contents at the read's falling edge.
REQ-017 MEM_WADDR, MEM_RADDR and MEM_WDATA SHALL hold their last value outside memory phases.

Reset
REQ-018 While RESETn=0, and immediately on assertion regardless of FSM state, outputs SHALL be:
- Both FSMs idle; AWREADY=WREADY=ARREADY=0.
- BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0.
- MEM_CS=MEM_WE=0; MEM_WADDR=MEM_RADDR=0; MEM_WDATA=0.
REQ-019 AWREADY, WREADY and ARREADY SHALL rise on the first rising edge after RESETn deasserts. An in-flight transaction aborted by reset SHALL produce no response.

Structure
REQ-020 A shared package SHALL hold the RESP_OKAY/RESP_SLVERR constants and the write/read state encodings.
REQ-021 The read and write FSMs SHALL be written as one module with no sub-modules.

Verification
REQ-022 The bench SHALL cover these directed scenarios, with memory bytes 0..9 preloaded to 0x00..0x09:
- Read ARADDR=0 -> RVALID one cycle after handshake, RDATA=0x03020100, RRESP=OKAY.
- Read ARADDR=1 with RREADY held low 3 cycles -> RDATA=0x04030201 stable all 3 cycles; FSM returns to R_IDLE after RREADY.
- W beat (0xDEADBEEF) two cycles before AW beat (addr 8) -> single-cycle MEM_WE with MEM_WADDR=8, MEM_WDATA=0xDEADBEEF; BVALID next cycle, BRESP=OKAY.
- Read ARADDR=125 -> no MEM_CS pulse, RRESP=SLVERR, RDATA=0; write AWADDR=126 -> no MEM_WE, BRESP=SLVERR.
- Write to 16 and read from 4 accepted in the same cycle -> both complete, MEM_WE and the read phase overlap, RDATA=0x07060504.
- RESETn asserted during R_RESP -> RVALID=0 immediately; ARREADY=1 one edge after release; no stale response.
